// File: rtl/ex_stage_alu_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_alu_branch_pkg
// Purpose  : Shared encodings for the EX stage: ALU opcodes, shift types,
//            condition codes, write-back selects and NZCV flag positions.
// Revision : 1.0  initial release
// ============================================================================
package ex_stage_alu_branch_pkg;

  // ALU operation encodings
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_ORR = 3'b011;
  localparam logic [2:0] c_ALU_EOR = 3'b100;
  localparam logic [2:0] c_ALU_MOV = 3'b101;
  localparam logic [2:0] c_ALU_MVN = 3'b110;
  localparam logic [2:0] c_ALU_CMP = 3'b111;

  // Barrel shifter type encodings
  localparam logic [1:0] c_SH_LSL = 2'b00;
  localparam logic [1:0] c_SH_LSR = 2'b01;
  localparam logic [1:0] c_SH_ASR = 2'b10;
  localparam logic [1:0] c_SH_ROR = 2'b11;

  // Condition code encodings (E and F both mean "always")
  localparam logic [3:0] c_COND_EQ = 4'h0;
  localparam logic [3:0] c_COND_NE = 4'h1;
  localparam logic [3:0] c_COND_CS = 4'h2;
  localparam logic [3:0] c_COND_CC = 4'h3;
  localparam logic [3:0] c_COND_MI = 4'h4;
  localparam logic [3:0] c_COND_PL = 4'h5;
  localparam logic [3:0] c_COND_VS = 4'h6;
  localparam logic [3:0] c_COND_VC = 4'h7;
  localparam logic [3:0] c_COND_HI = 4'h8;
  localparam logic [3:0] c_COND_LS = 4'h9;
  localparam logic [3:0] c_COND_GE = 4'hA;
  localparam logic [3:0] c_COND_LT = 4'hB;
  localparam logic [3:0] c_COND_GT = 4'hC;
  localparam logic [3:0] c_COND_LE = 4'hD;

  // Write-back source encodings
  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_MEM  = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;
  localparam logic [1:0] c_WB_NONE = 2'b11;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  // Flag group as produced by the ALU before it is committed
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage : ex_stage_alu_branch_pkg
`default_nettype wire

// File: rtl/ex_stage_alu_branch_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ex_barrel_shifter
// Purpose  : Combinational barrel shifter (LSL/LSR/ASR/ROR) that also
//            reports the last bit shifted out. Zero amount passes the data
//            through and returns the incoming carry.
// Revision : 1.0  initial release
// ============================================================================
module ex_barrel_shifter #(
  parameter int DW = 16,
  parameter int SW = 4
) (
  input  logic [DW-1:0] i_data,
  input  logic [1:0]    i_type,
  input  logic [SW-1:0] i_amount,
  input  logic          i_carry,
  output logic [DW-1:0] o_data,
  output logic          o_carry
);
  import ex_stage_alu_branch_pkg::*;

  // Each form is widened by one guard bit so the bit shifted out lands at a
  // fixed position; ROR uses a doubled copy of the data.
  logic [DW:0]      w_lsl;
  logic [DW:0]      w_lsr;
  logic [DW:0]      w_asr;
  logic [2*DW:0]    w_ror;

  assign w_lsl = {1'b0, i_data} << i_amount;
  assign w_lsr = {i_data, 1'b0} >> i_amount;
  assign w_asr = $unsigned($signed({i_data, 1'b0}) >>> i_amount);
  assign w_ror = {i_data, i_data, 1'b0} >> i_amount;

  // Select the shift form and its carry-out; amount 0 is a pass-through
  always_comb begin
    o_data  = i_data;
    o_carry = i_carry;
    if (i_amount != '0) begin
      case (i_type)
        c_SH_LSL: begin
          o_data  = w_lsl[DW-1:0];
          o_carry = w_lsl[DW];
        end
        c_SH_LSR: begin
          o_data  = w_lsr[DW:1];
          o_carry = w_lsr[0];
        end
        c_SH_ASR: begin
          o_data  = w_asr[DW:1];
          o_carry = w_asr[0];
        end
        default: begin
          o_data  = w_ror[DW:1];
          o_carry = w_ror[0];
        end
      endcase
    end
  end

endmodule : ex_barrel_shifter
`default_nettype wire

// File: rtl/ex_stage_alu_branch.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_alu_branch
// Purpose  : Execute stage of the 16-bit 5-stage pipeline: operand select,
//            barrel shift, ALU, NZCV update, condition check and branch
//            resolution, registered into the EX/MEM boundary.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage_alu_branch #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_stall,
  input  logic          ex_flush,
  input  logic          RegWrite_r,
  input  logic          ALUsrc_r,
  input  logic          mem_read_r,
  input  logic          mem_write_r,
  input  logic          cond_branch_r,
  input  logic          uncond_branch_r,
  input  logic          link_branch_r,
  input  logic          reg_branch_r,
  input  logic          alu_shift_r,
  input  logic [1:0]    shift_type_r,
  input  logic [2:0]    ALUop_r,
  input  logic [3:0]    conditions_r,
  input  logic [1:0]    write_back_r,
  input  logic [1:0]    branch_type_r,
  input  logic [AW-1:0] write_address_r,
  input  logic [DW-1:0] read_data1_r,
  input  logic [DW-1:0] read_data2_r,
  input  logic [DW-1:0] immediate_data_r,
  input  logic [DW-1:0] link_pc_r,
  output logic          RegWrite_m,
  output logic          mem_read_m,
  output logic          mem_write_m,
  output logic [1:0]    write_back_m,
  output logic [1:0]    branch_type_m,
  output logic [AW-1:0] write_address_m,
  output logic [DW-1:0] alu_result_m,
  output logic [DW-1:0] store_data_m,
  output logic          branch_taken_m,
  output logic [DW-1:0] branch_target_m,
  output logic [3:0]    flags_q
);
  import ex_stage_alu_branch_pkg::*;

  // EX/MEM boundary and architectural flags
  logic          r_regwrite_m;
  logic          r_mem_read_m;
  logic          r_mem_write_m;
  logic [1:0]    r_write_back_m;
  logic [1:0]    r_branch_type_m;
  logic [AW-1:0] r_write_address_m;
  logic [DW-1:0] r_alu_result_m;
  logic [DW-1:0] r_store_data_m;
  logic          r_branch_taken_m;
  logic [DW-1:0] r_branch_target_m;
  logic [3:0]    r_flags;

  // Datapath
  logic [DW-1:0] w_b0;
  logic [DW-1:0] w_b_sh;
  logic          w_sh_carry;
  logic [DW-1:0] w_b;
  logic          w_logic_c;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_alu_res;
  nzcv_t         w_new;
  logic [DW-1:0] w_target;
  logic [DW-1:0] w_result;

  // Control
  logic          w_cond_ok;
  logic          w_is_cmp;
  logic          w_any_branch;
  logic          w_live;
  logic          w_flag_we;
  logic          w_regwrite;
  logic [1:0]    w_wb;
  logic [AW-1:0] w_wa;

  assign w_b0 = ALUsrc_r ? immediate_data_r : read_data2_r;

  ex_barrel_shifter #(
    .DW (DW),
    .SW (4)
  ) u_shifter (
    .i_data   (w_b0),
    .i_type   (shift_type_r),
    .i_amount (immediate_data_r[3:0]),
    .i_carry  (r_flags[c_FLAG_C]),
    .o_data   (w_b_sh),
    .o_carry  (w_sh_carry)
  );

  assign w_b       = alu_shift_r ? w_b_sh : w_b0;
  // Logic ops take the shifter carry only when a shift was actually requested
  assign w_logic_c = alu_shift_r ? w_sh_carry : r_flags[c_FLAG_C];

  // Carry-out of the subtract path is the inverted borrow
  assign w_sum  = {1'b0, read_data1_r} + {1'b0, w_b};
  assign w_diff = {1'b0, read_data1_r} + {1'b0, ~w_b} + {{DW{1'b0}}, 1'b1};

  // ALU result and candidate flags
  always_comb begin
    w_alu_res = w_sum[DW-1:0];
    w_new.c   = w_logic_c;
    w_new.v   = r_flags[c_FLAG_V];
    case (ALUop_r)
      c_ALU_ADD: begin
        w_alu_res = w_sum[DW-1:0];
        w_new.c   = w_sum[DW];
        w_new.v   = (read_data1_r[DW-1] == w_b[DW-1]) &&
                    (w_sum[DW-1] != read_data1_r[DW-1]);
      end
      c_ALU_SUB, c_ALU_CMP: begin
        w_alu_res = w_diff[DW-1:0];
        w_new.c   = w_diff[DW];
        w_new.v   = (read_data1_r[DW-1] != w_b[DW-1]) &&
                    (w_diff[DW-1] != read_data1_r[DW-1]);
      end
      c_ALU_AND: w_alu_res = read_data1_r & w_b;
      c_ALU_ORR: w_alu_res = read_data1_r | w_b;
      c_ALU_EOR: w_alu_res = read_data1_r ^ w_b;
      c_ALU_MOV: w_alu_res = w_b;
      default:   w_alu_res = ~w_b;
    endcase
    w_new.n = w_alu_res[DW-1];
    w_new.z = (w_alu_res == '0);
  end

  // Predicate check against the flags as they stood before this instruction
  always_comb begin
    w_cond_ok = 1'b1;
    case (conditions_r)
      c_COND_EQ: w_cond_ok = r_flags[c_FLAG_Z];
      c_COND_NE: w_cond_ok = !r_flags[c_FLAG_Z];
      c_COND_CS: w_cond_ok = r_flags[c_FLAG_C];
      c_COND_CC: w_cond_ok = !r_flags[c_FLAG_C];
      c_COND_MI: w_cond_ok = r_flags[c_FLAG_N];
      c_COND_PL: w_cond_ok = !r_flags[c_FLAG_N];
      c_COND_VS: w_cond_ok = r_flags[c_FLAG_V];
      c_COND_VC: w_cond_ok = !r_flags[c_FLAG_V];
      c_COND_HI: w_cond_ok = r_flags[c_FLAG_C] && !r_flags[c_FLAG_Z];
      c_COND_LS: w_cond_ok = !r_flags[c_FLAG_C] || r_flags[c_FLAG_Z];
      c_COND_GE: w_cond_ok = (r_flags[c_FLAG_N] == r_flags[c_FLAG_V]);
      c_COND_LT: w_cond_ok = (r_flags[c_FLAG_N] != r_flags[c_FLAG_V]);
      c_COND_GT: w_cond_ok = !r_flags[c_FLAG_Z] &&
                             (r_flags[c_FLAG_N] == r_flags[c_FLAG_V]);
      c_COND_LE: w_cond_ok = r_flags[c_FLAG_Z] ||
                             (r_flags[c_FLAG_N] != r_flags[c_FLAG_V]);
      default:   w_cond_ok = 1'b1;
    endcase
  end

  assign w_is_cmp     = (ALUop_r == c_ALU_CMP);
  assign w_any_branch = cond_branch_r | uncond_branch_r | link_branch_r | reg_branch_r;
  // An instruction is live only if its predicate holds and it has some effect
  assign w_live       = w_cond_ok & ~ex_flush &
                        (RegWrite_r | w_is_cmp | w_any_branch | mem_read_r | mem_write_r);
  assign w_flag_we    = w_live & ~ex_stall &
                        ((RegWrite_r & (write_back_r == c_WB_ALU)) | w_is_cmp);

  // Link branches write PC+1 into the top register; CMP never writes back
  assign w_regwrite = link_branch_r | (RegWrite_r & ~w_is_cmp);
  assign w_wb       = link_branch_r ? c_WB_LINK : write_back_r;
  assign w_wa       = link_branch_r ? {AW{1'b1}} : write_address_r;
  assign w_result   = (w_wb == c_WB_LINK) ? link_pc_r : w_alu_res;
  assign w_target   = reg_branch_r ? read_data1_r : (link_pc_r + immediate_data_r);

  // EX/MEM register and flags: reset > flush > stall > bubble > load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite_m      <= 1'b0;
      r_mem_read_m      <= 1'b0;
      r_mem_write_m     <= 1'b0;
      r_write_back_m    <= 2'b00;
      r_branch_type_m   <= 2'b00;
      r_write_address_m <= '0;
      r_alu_result_m    <= '0;
      r_store_data_m    <= '0;
      r_branch_taken_m  <= 1'b0;
      r_branch_target_m <= '0;
      r_flags           <= 4'h0;
    end else if (ex_flush || (!ex_stall && !w_live)) begin
      r_regwrite_m      <= 1'b0;
      r_mem_read_m      <= 1'b0;
      r_mem_write_m     <= 1'b0;
      r_write_back_m    <= 2'b00;
      r_branch_type_m   <= 2'b00;
      r_write_address_m <= '0;
      r_alu_result_m    <= '0;
      r_store_data_m    <= '0;
      r_branch_taken_m  <= 1'b0;
      r_branch_target_m <= '0;
    end else if (!ex_stall) begin
      r_regwrite_m      <= w_regwrite;
      r_mem_read_m      <= mem_read_r;
      r_mem_write_m     <= mem_write_r;
      r_write_back_m    <= w_wb;
      r_branch_type_m   <= branch_type_r;
      r_write_address_m <= w_wa;
      r_alu_result_m    <= w_result;
      r_store_data_m    <= read_data2_r;
      r_branch_taken_m  <= w_any_branch;
      r_branch_target_m <= w_target;
      if (w_flag_we) begin
        r_flags <= w_new;
      end
    end
  end

  assign RegWrite_m      = r_regwrite_m;
  assign mem_read_m      = r_mem_read_m;
  assign mem_write_m     = r_mem_write_m;
  assign write_back_m    = r_write_back_m;
  assign branch_type_m   = r_branch_type_m;
  assign write_address_m = r_write_address_m;
  assign alu_result_m    = r_alu_result_m;
  assign store_data_m    = r_store_data_m;
  assign branch_taken_m  = r_branch_taken_m;
  assign branch_target_m = r_branch_target_m;
  assign flags_q         = r_flags;

endmodule : ex_stage_alu_branch
`default_nettype wire

// File: tb/tb_ex_stage_alu_branch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_alu_branch
// Purpose  : Self-checking bench for ex_stage_alu_branch: directed scenarios
//            plus randomized traffic against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_alu_branch;

  logic        clk = 1'b0;
  logic        reset, ex_stall, ex_flush;
  logic        RegWrite_r, ALUsrc_r, mem_read_r, mem_write_r;
  logic        cond_branch_r, uncond_branch_r, link_branch_r, reg_branch_r, alu_shift_r;
  logic [1:0]  shift_type_r, write_back_r, branch_type_r;
  logic [2:0]  ALUop_r;
  logic [3:0]  conditions_r, write_address_r;
  logic [15:0] read_data1_r, read_data2_r, immediate_data_r, link_pc_r;
  logic        RegWrite_m, mem_read_m, mem_write_m, branch_taken_m;
  logic [1:0]  write_back_m, branch_type_m;
  logic [3:0]  write_address_m, flags_q;
  logic [15:0] alu_result_m, store_data_m, branch_target_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_stage_alu_branch #(.DW(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .RegWrite_r(RegWrite_r), .ALUsrc_r(ALUsrc_r), .mem_read_r(mem_read_r),
    .mem_write_r(mem_write_r), .cond_branch_r(cond_branch_r),
    .uncond_branch_r(uncond_branch_r), .link_branch_r(link_branch_r),
    .reg_branch_r(reg_branch_r), .alu_shift_r(alu_shift_r),
    .shift_type_r(shift_type_r), .ALUop_r(ALUop_r), .conditions_r(conditions_r),
    .write_back_r(write_back_r), .branch_type_r(branch_type_r),
    .write_address_r(write_address_r), .read_data1_r(read_data1_r),
    .read_data2_r(read_data2_r), .immediate_data_r(immediate_data_r),
    .link_pc_r(link_pc_r), .RegWrite_m(RegWrite_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .write_back_m(write_back_m),
    .branch_type_m(branch_type_m), .write_address_m(write_address_m),
    .alu_result_m(alu_result_m), .store_data_m(store_data_m),
    .branch_taken_m(branch_taken_m), .branch_target_m(branch_target_m),
    .flags_q(flags_q)
  );

  // Expected EX/MEM contents
  typedef struct {
    logic        rw, mr, mw, taken;
    logic [1:0]  wb, bt;
    logic [3:0]  wa, flags;
    logic [15:0] res, sd, tgt;
  } exp_t;

  function automatic exp_t bubble_of(input logic [3:0] fl);
    exp_t e;
    e.rw = 0; e.mr = 0; e.mw = 0; e.taken = 0; e.wb = 0; e.bt = 0;
    e.wa = 0; e.res = 0; e.sd = 0; e.tgt = 0; e.flags = fl;
    return e;
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {e.rw, e.mr, e.mw, e.wb, e.bt, e.wa, e.res, e.sd, e.taken, e.tgt, e.flags};
  endfunction

  function automatic logic [63:0] pack_dut();
    return {RegWrite_m, mem_read_m, mem_write_m, write_back_m, branch_type_m,
            write_address_m, alu_result_m, store_data_m, branch_taken_m,
            branch_target_m, flags_q};
  endfunction

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference model: next EX/MEM state from the current inputs and state
  function automatic exp_t model_next(input exp_t cur);
    exp_t n;
    int a, b0, b, amt, sc, r, c, v, sa, sb, t;
    bit fn, fz, fc, fv, ok, live, br, cmp;
    if (reset) return bubble_of(4'h0);
    if (ex_flush) return bubble_of(cur.flags);
    if (ex_stall) return cur;
    fn = cur.flags[3]; fz = cur.flags[2]; fc = cur.flags[1]; fv = cur.flags[0];
    case (conditions_r)
      4'h0: ok = fz;        4'h1: ok = !fz;
      4'h2: ok = fc;        4'h3: ok = !fc;
      4'h4: ok = fn;        4'h5: ok = !fn;
      4'h6: ok = fv;        4'h7: ok = !fv;
      4'h8: ok = fc && !fz; 4'h9: ok = !fc || fz;
      4'hA: ok = (fn == fv); 4'hB: ok = (fn != fv);
      4'hC: ok = !fz && (fn == fv); 4'hD: ok = fz || (fn != fv);
      default: ok = 1;
    endcase
    br   = cond_branch_r || uncond_branch_r || link_branch_r || reg_branch_r;
    cmp  = (ALUop_r == 3'd7);
    live = ok && (RegWrite_r || cmp || br || mem_read_r || mem_write_r);
    if (!live) return bubble_of(cur.flags);
    a  = read_data1_r;
    b0 = ALUsrc_r ? immediate_data_r : read_data2_r;
    amt = immediate_data_r & 15;
    b = b0; sc = fc;
    if (alu_shift_r && amt != 0) begin
      case (shift_type_r)
        2'd0: begin b = (b0 << amt) & 65535; sc = (b0 >> (16 - amt)) & 1; end
        2'd1: begin b = b0 >> amt; sc = (b0 >> (amt - 1)) & 1; end
        2'd2: begin b = (to_signed16(b0) >>> amt) & 65535; sc = (b0 >> (amt - 1)) & 1; end
        default: begin
          b = ((b0 >> amt) | (b0 << (16 - amt))) & 65535; sc = (b0 >> (amt - 1)) & 1;
        end
      endcase
    end
    sa = to_signed16(a); sb = to_signed16(b);
    c = sc; v = fv;
    case (ALUop_r)
      3'd0: begin
        t = a + b; r = t & 65535; c = (t > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1, 3'd7: begin
        r = (a - b) & 65535; c = (a >= b);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      default: r = (~b) & 65535;
    endcase
    n.rw    = link_branch_r ? 1'b1 : (cmp ? 1'b0 : RegWrite_r);
    n.wb    = link_branch_r ? 2'd2 : write_back_r;
    n.wa    = link_branch_r ? 4'hF : write_address_r;
    n.res   = (n.wb == 2'd2) ? link_pc_r : 16'(r);
    n.sd    = read_data2_r;
    n.mr    = mem_read_r;
    n.mw    = mem_write_r;
    n.bt    = branch_type_r;
    n.taken = br;
    n.tgt   = reg_branch_r ? read_data1_r : 16'((link_pc_r + immediate_data_r) & 65535);
    if ((RegWrite_r && write_back_r == 2'd0) || cmp)
      n.flags = {r >= 32768, r == 0, c[0], v[0]};
    else
      n.flags = cur.flags;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; ex_stall = 0; ex_flush = 0;
    RegWrite_r = 0; ALUsrc_r = 0; mem_read_r = 0; mem_write_r = 0;
    cond_branch_r = 0; uncond_branch_r = 0; link_branch_r = 0; reg_branch_r = 0;
    alu_shift_r = 0; shift_type_r = 0; ALUop_r = 0; conditions_r = 4'hE;
    write_back_r = 0; branch_type_r = 0; write_address_r = 0;
    read_data1_r = 0; read_data2_r = 0; immediate_data_r = 0; link_pc_r = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; RegWrite_r = 1; read_data1_r = 16'h1234; uncond_branch_r = 1;
    tick(); tick();
    n_cmp++;
    if (pack_dut() !== 64'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", pack_dut(), 64'h0);
    end
    clear_inputs();
  endtask

  task automatic test_add_overflow();
    clear_inputs();
    RegWrite_r = 1; ALUop_r = 3'd0; read_data1_r = 16'h7FFF; read_data2_r = 16'h0001;
    write_address_r = 4'h3;
    tick();
    n_cmp++;
    if (alu_result_m !== 16'h8000) begin
      n_bad++; $display("FAIL add_result: got %h want 8000", alu_result_m);
    end
    n_cmp++;
    if (flags_q !== 4'b1001) begin
      n_bad++; $display("FAIL add_flags: got %b want 1001", flags_q);
    end
    n_cmp++;
    if ({RegWrite_m, write_address_m} !== 5'b1_0011) begin
      n_bad++; $display("FAIL add_ctrl: got %b want 10011", {RegWrite_m, write_address_m});
    end
    clear_inputs();
  endtask

  task automatic test_cmp_beq_bne();
    clear_inputs();
    ALUop_r = 3'd7; ALUsrc_r = 1; read_data1_r = 16'h0005; immediate_data_r = 16'h0005;
    RegWrite_r = 1;
    tick();
    n_cmp++;
    if ({RegWrite_m, flags_q} !== 5'b0_0110) begin
      n_bad++; $display("FAIL cmp_rw_flags: got %b want 00110", {RegWrite_m, flags_q});
    end
    clear_inputs();
    cond_branch_r = 1; conditions_r = 4'h0; link_pc_r = 16'h0010; immediate_data_r = 16'h0004;
    tick();
    n_cmp++;
    if ({branch_taken_m, branch_target_m} !== {1'b1, 16'h0014}) begin
      n_bad++; $display("FAIL beq_taken: got %b/%h want 1/0014", branch_taken_m, branch_target_m);
    end
    clear_inputs();
    cond_branch_r = 1; conditions_r = 4'h1; RegWrite_r = 1; mem_write_r = 1;
    read_data1_r = 16'h0001; read_data2_r = 16'h0001;
    tick();
    n_cmp++;
    if ({RegWrite_m, mem_read_m, mem_write_m, branch_taken_m, alu_result_m} !== 20'h0) begin
      n_bad++; $display("FAIL bne_bubble: got %h want 00000",
                        {RegWrite_m, mem_read_m, mem_write_m, branch_taken_m, alu_result_m});
    end
    n_cmp++;
    if (flags_q !== 4'b0110) begin
      n_bad++; $display("FAIL bne_flags: got %b want 0110", flags_q);
    end
    clear_inputs();
  endtask

  task automatic test_shifts();
    clear_inputs();
    RegWrite_r = 1; ALUop_r = 3'd5; alu_shift_r = 1; shift_type_r = 2'd1;
    read_data2_r = 16'h0003; immediate_data_r = 16'h0001;
    tick();
    n_cmp++;
    if ({alu_result_m, flags_q} !== {16'h0001, 4'b0010}) begin
      n_bad++; $display("FAIL lsr1: got %h/%b want 0001/0010", alu_result_m, flags_q);
    end
    shift_type_r = 2'd3; read_data2_r = 16'h1234; immediate_data_r = 16'h0004;
    tick();
    n_cmp++;
    if ({alu_result_m, flags_q} !== {16'h4123, 4'b0000}) begin
      n_bad++; $display("FAIL ror4: got %h/%b want 4123/0000", alu_result_m, flags_q);
    end
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    RegWrite_r = 1; read_data1_r = 16'h0001; read_data2_r = 16'h0002;
    tick();
    read_data1_r = 16'hFFFF; read_data2_r = 16'h0001; ex_stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({alu_result_m, flags_q} !== {16'h0003, 4'b0000}) begin
        n_bad++; $display("FAIL stall_hold%0d: got %h/%b want 0003/0000", i, alu_result_m, flags_q);
      end
    end
    ex_stall = 0;
    tick();
    n_cmp++;
    if ({alu_result_m, flags_q} !== {16'h0000, 4'b0110}) begin
      n_bad++; $display("FAIL stall_release: got %h/%b want 0000/0110", alu_result_m, flags_q);
    end
    read_data1_r = 16'h0001; read_data2_r = 16'h0001; ex_stall = 1; ex_flush = 1;
    tick();
    n_cmp++;
    if ({RegWrite_m, branch_taken_m, alu_result_m, flags_q} !== {2'b00, 16'h0000, 4'b0110}) begin
      n_bad++; $display("FAIL flush_over_stall: got %h want 00006",
                        {RegWrite_m, branch_taken_m, alu_result_m, flags_q});
    end
    clear_inputs();
  endtask

  task automatic test_bl_wrap_reset();
    clear_inputs();
    link_branch_r = 1; link_pc_r = 16'h00FF; immediate_data_r = 16'hFF10;
    tick();
    n_cmp++;
    if ({branch_taken_m, branch_target_m, write_address_m, alu_result_m} !==
        {1'b1, 16'h000F, 4'hF, 16'h00FF}) begin
      n_bad++; $display("FAIL bl_wrap: got %h want 1000ff00ff",
                        {branch_taken_m, branch_target_m, write_address_m, alu_result_m});
    end
    n_cmp++;
    if ({RegWrite_m, write_back_m} !== 3'b110) begin
      n_bad++; $display("FAIL bl_link_wb: got %b want 110", {RegWrite_m, write_back_m});
    end
    RegWrite_r = 1; read_data1_r = 16'h8000; read_data2_r = 16'h8000; reset = 1;
    tick();
    n_cmp++;
    if (pack_dut() !== 64'h0) begin
      n_bad++; $display("FAIL mid_reset: got %h want 0", pack_dut());
    end
    clear_inputs();
  endtask

  task automatic test_random();
    exp_t cur, nxt;
    logic [15:0] edge_v [5] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    clear_inputs();
    reset = 1;
    tick();
    cur = bubble_of(4'h0);
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(39) == 0);
      ex_stall        = ($urandom_range(5) == 0);
      ex_flush        = ($urandom_range(9) == 0);
      RegWrite_r      = ($urandom_range(3) != 0);
      ALUsrc_r        = 1'($urandom);
      mem_read_r      = ($urandom_range(7) == 0);
      mem_write_r     = ($urandom_range(7) == 0);
      cond_branch_r   = ($urandom_range(5) == 0);
      uncond_branch_r = ($urandom_range(9) == 0);
      link_branch_r   = ($urandom_range(9) == 0);
      reg_branch_r    = ($urandom_range(9) == 0);
      alu_shift_r     = 1'($urandom);
      shift_type_r    = 2'($urandom);
      ALUop_r         = 3'($urandom);
      conditions_r    = ($urandom_range(1) == 0) ? 4'hE : 4'($urandom);
      write_back_r    = 2'($urandom);
      branch_type_r   = 2'($urandom);
      write_address_r = 4'($urandom);
      read_data1_r    = ($urandom_range(3) == 0) ? edge_v[$urandom_range(4)] : 16'($urandom);
      read_data2_r    = ($urandom_range(3) == 0) ? edge_v[$urandom_range(4)] : 16'($urandom);
      immediate_data_r = 16'($urandom);
      link_pc_r       = 16'($urandom);
      nxt = model_next(cur);
      tick();
      n_cmp++;
      if (pack_dut() !== pack_exp(nxt)) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, pack_dut(), pack_exp(nxt));
      end
      cur = nxt;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_add_overflow();
    test_cmp_beq_bne();
    test_shifts();
    test_stall_flush();
    test_bl_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ex_stage_alu_branch
`default_nettype wire
